// File: rtl/dvi_mode_if.sv
// Mode-change request bus between control logic and dvi_mode_sequencer.
// master: control side (drives valid/mode), slave: the sequencer.
interface dvi_mode_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_mode;
  logic       req_error;

  modport master (output req_valid, output req_mode, input req_ready, input req_error);
  modport slave  (input req_valid, input req_mode, output req_ready, output req_error);
endinterface

// File: rtl/dvi_mode_sequencer.sv
// dvi_mode_sequencer: applies video timing modes on frame boundaries.
// A request is accepted in RUN, the block waits for a vsync rising edge
// (DRAIN), loads the new timing row (LOAD), holds the pattern generator in
// reset (HOLD), then stays muted for MUTE_FRAMES frames (SETTLE).
// Optional build macro DVI_MODE_SEQ_WATCHDOG_EN: a cycle watchdog in DRAIN
// and SETTLE that synthesises a frame edge when vsync is dead or stuck.
module dvi_mode_sequencer #(
  parameter int DEFAULT_MODE    = 2,
  parameter int RESET_CYCLES    = 16,
  parameter int MUTE_FRAMES     = 2,
  parameter int WATCHDOG_CYCLES = 16777216
) (
  input  logic        clock,
  input  logic        reset,
  dvi_mode_if.slave   req,
  input  logic        video_vsync,
  output logic [1:0]  mode_current,
  output logic        busy,
  output logic        tpg_reset,
  output logic        mute,
  output logic [11:0] h_sync,
  output logic [11:0] h_back,
  output logic [11:0] h_active,
  output logic [11:0] h_front,
  output logic [11:0] v_sync,
  output logic [11:0] v_back,
  output logic [11:0] v_active,
  output logic [11:0] v_front,
  output logic        wdt_timeout
);

  // One shared counter serves HOLD (cycles) and SETTLE (frames); the
  // watchdog counter uses the same width so one sizing rule covers both.
  localparam int CNT_MAX_RM = (RESET_CYCLES > MUTE_FRAMES) ? RESET_CYCLES : MUTE_FRAMES;
  localparam int CNT_MAX    = (CNT_MAX_RM > WATCHDOG_CYCLES) ? CNT_MAX_RM : WATCHDOG_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUTE_LAST = (MUTE_FRAMES > 0) ? CNT_W'(MUTE_FRAMES - 1) : '0;
  localparam logic [1:0]       DEF_M     = 2'(DEFAULT_MODE);

  localparam logic [2:0] S_RUN    = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;

  typedef struct packed {
    logic [11:0] hs, hb, ha, hf;
    logic [11:0] vs, vb, va, vf;
  } timing_t;

  // Mode table: sync/back/active/front for H then V. Mode 3 is never
  // loaded (rejected at the handshake); it maps to the mode 2 row.
  function automatic timing_t mode_row(input logic [1:0] m);
    timing_t t;
    case (m)
      2'd0:    t = '{12'd40,  12'd220, 12'd1280, 12'd110, 12'd5, 12'd20, 12'd720,  12'd5};
      2'd1:    t = '{12'd44,  12'd148, 12'd1920, 12'd88,  12'd5, 12'd36, 12'd1080, 12'd4};
      default: t = '{12'd192, 12'd304, 12'd1600, 12'd64,  12'd3, 12'd46, 12'd1200, 12'd1};
    endcase
    return t;
  endfunction

  logic [2:0]       st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             vs_d;
  logic             vs_edge;
  logic             frame_edge;
  logic             wait_st;
  logic             acc_ok, acc_bad;
  logic [1:0]       pend_mode;
  logic [1:0]       mode_q;
  timing_t          tim_q;
  logic             err_q;

  assign vs_edge = video_vsync & ~vs_d;
  assign wait_st = (st == S_DRAIN) || (st == S_SETTLE);

`ifdef DVI_MODE_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WATCHDOG_CYCLES - 1);

  logic [CNT_W-1:0] wcnt;
  logic             wdt_fire;
  logic             wdt_q;

  // A real edge always wins; the watchdog only fills in for a missing one.
  assign wdt_fire   = wait_st && !vs_edge && (wcnt == WDT_LAST);
  assign frame_edge = vs_edge | wdt_fire;

  // Watchdog counter: runs only while waiting for a frame edge, cleared by
  // any (real or synthetic) edge and held at zero in all other states, so it
  // is already zero on DRAIN/SETTLE entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt  <= '0;
      wdt_q <= 1'b0;
    end else begin
      wdt_q <= wdt_fire;
      wcnt  <= (wait_st && !frame_edge) ? wcnt + CNT_W'(1) : '0;
    end
  end

  assign wdt_timeout = wdt_q;
`else
  assign frame_edge  = vs_edge;
  assign wdt_timeout = 1'b0;
`endif

  // Next-state and counter logic for the resync sequence.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    acc_ok  = 1'b0;
    acc_bad = 1'b0;
    case (st)
      S_RUN: begin
        if (req.req_valid) begin
          if (req.req_mode == 2'd3) begin
            acc_bad = 1'b1;
          end else begin
            acc_ok = 1'b1;
            st_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (frame_edge) st_nxt = S_LOAD;
      end
      S_LOAD: begin
        st_nxt  = S_HOLD;
        cnt_nxt = '0;
      end
      S_HOLD: begin
        // Vsync is ignored here: the generator is in reset and its vsync
        // is meaningless until release.
        if (cnt == RST_LAST) begin
          st_nxt  = S_SETTLE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (MUTE_FRAMES == 0) begin
          st_nxt = S_RUN;
        end else if (frame_edge) begin
          if (cnt == MUTE_LAST) begin
            st_nxt  = S_RUN;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        st_nxt  = S_HOLD;
        cnt_nxt = '0;
      end
    endcase
  end

  // State, counter and vsync history registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      st   <= S_HOLD;
      cnt  <= '0;
      vs_d <= 1'b0;
    end else begin
      st   <= st_nxt;
      cnt  <= cnt_nxt;
      vs_d <= video_vsync;
    end
  end

  // Request capture and the one-cycle invalid-mode pulse; a reset drops
  // any request still waiting in DRAIN.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_mode <= DEF_M;
      err_q     <= 1'b0;
    end else begin
      err_q <= acc_bad;
      if (acc_ok) pend_mode <= req.req_mode;
    end
  end

  // Timing row and mode_current change only when leaving LOAD, so they
  // are stable for the whole frame in every other state.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= DEF_M;
      tim_q  <= mode_row(DEF_M);
    end else if (st == S_LOAD) begin
      mode_q <= pend_mode;
      tim_q  <= mode_row(pend_mode);
    end
  end

  // Control outputs decode straight from the state register; reset lands
  // in HOLD, which gives the required reset values.
  assign req.req_ready = (st == S_RUN);
  assign req.req_error = err_q;
  assign busy          = (st != S_RUN);
  assign tpg_reset     = (st == S_HOLD);
  assign mute          = (st == S_LOAD) || (st == S_HOLD) || (st == S_SETTLE);
  assign mode_current  = mode_q;

  assign h_sync   = tim_q.hs;
  assign h_back   = tim_q.hb;
  assign h_active = tim_q.ha;
  assign h_front  = tim_q.hf;
  assign v_sync   = tim_q.vs;
  assign v_back   = tim_q.vb;
  assign v_active = tim_q.va;
  assign v_front  = tim_q.vf;

endmodule
